// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Issues 16-bit instructions to an external 8-bit ALU, runs
//            MUL/LDI/traps locally and writes results back to a 4x8 regfile.
// Revision : 1.0
// ============================================================================
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  input  logic [7:0]  alu_result,
  output logic        done,
  output logic [7:0]  result,
  output logic        zero,
  output logic        err
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_MUL  = 2'd2;
  localparam logic [1:0] c_WB   = 2'd3;

  localparam logic [3:0] c_OP_MUL  = 4'b0011;
  localparam logic [3:0] c_OP_ILL0 = 4'b0100;
  localparam logic [3:0] c_OP_LDI  = 4'b1011;
  localparam logic [3:0] c_OP_ILL1 = 4'b1111;

  logic [1:0]      r_state;
  logic [3:0][7:0] r_rf;
  logic [3:0]      r_op;
  logic [1:0]      r_dst;
  logic [7:0]      r_imm;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [7:0]      r_wb;
  logic [7:0]      r_acc;
  logic [7:0]      r_mcand;
  logic [7:0]      r_mplier;
  logic [2:0]      r_cnt;
  logic [7:0]      r_result;
  logic            r_zero;
  logic            r_err;

  logic            w_illegal;
  logic            w_mul;
  logic            w_ldi;
  logic [7:0]      w_acc_next;

  assign w_illegal  = (r_op == c_OP_ILL0) || (r_op == c_OP_ILL1);
  assign w_mul      = (r_op == c_OP_MUL);
  assign w_ldi      = (r_op == c_OP_LDI);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 8'h00);

  // Only genuine ALU-class opcodes reach the ALU, and only while in EXEC.
  always_comb begin
    alu_opcode = 4'b0000;
    if (r_state == c_EXEC && !w_illegal && !w_mul && !w_ldi)
      alu_opcode = r_op;
  end

  assign instr_ready = (r_state == c_IDLE);
  assign done        = (r_state == c_WB) || ((r_state == c_EXEC) && w_illegal);
  assign alu_op1     = r_a;
  assign alu_op2     = r_b;
  assign result      = r_result;
  assign zero        = r_zero;
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_rf     <= '0;
      r_op     <= '0;
      r_dst    <= '0;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_wb     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (instr_valid) begin
            r_op    <= instr[15:12];
            r_dst   <= instr[11:10];
            r_imm   <= instr[7:0];
            r_a     <= r_rf[instr[9:8]];
            r_b     <= r_rf[instr[7:6]];
            r_state <= c_EXEC;
          end
        end
        c_EXEC: begin
          if (w_illegal) begin
            r_err   <= 1'b1;
            r_state <= c_IDLE;
          end else if (w_ldi) begin
            r_wb    <= r_imm;
            r_state <= c_WB;
          end else if (w_mul) begin
            r_acc    <= '0;
            r_mcand  <= r_a;
            r_mplier <= r_b;
            r_cnt    <= '0;
            r_state  <= c_MUL;
          end else begin
            r_wb    <= alu_result;
            r_state <= c_WB;
          end
        end
        c_MUL: begin
          // LSB-first shift-add; bits shifted past bit 7 are the discarded overflow.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_wb    <= w_acc_next;
            r_state <= c_WB;
          end
        end
        c_WB: begin
          r_rf[r_dst] <= r_wb;
          r_result    <= r_wb;
          r_zero      <= (r_wb == 8'h00);
          r_state     <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
